// File: rtl/fnd_scheduler.sv
// fnd_scheduler: arbitrates live value, timed messages and sticky error onto fnd_serial.
// Define FND_BLINK_EN to blink the error display on every tick.
module fnd_scheduler #(
  parameter int HOLD_TICKS = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        val_valid,
  input  logic [31:0] val_data,
  input  logic        msg_req,
  input  logic [31:0] msg_code,
  output logic        msg_ack,
  input  logic        err_req,
  input  logic        err_clr,
  output logic [31:0] fnd_serial,
  output logic        busy
);
  localparam logic [31:0] NULL_CODE = 32'h00CC_0000;
  localparam logic [31:0] ERR_CODE  = 32'h00EE_0000;
  localparam logic [3:0]  HOLD      = 4'(HOLD_TICKS);
  typedef enum logic [1:0] {IDLE, MSG, ERR} state_t;
  state_t      r_state;
  logic [31:0] r_val, r_act, r_pend;
  logic        r_val_seen, r_pend_vld;
  logic [3:0]  r_hold;
  logic        w_acc, w_exp;
  logic [31:0] w_err_disp;
`ifdef FND_BLINK_EN
  logic        r_blink;
  assign w_err_disp = r_blink ? NULL_CODE : ERR_CODE;
`else
  assign w_err_disp = ERR_CODE;
`endif
  // masking with msg_ack keeps a still-high request from being taken twice
  assign w_acc = msg_req && !msg_ack;
  assign w_exp = tick && r_hold == 4'd1;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= IDLE;
      r_val      <= '0;
      r_val_seen <= 1'b0;
      r_act      <= '0;
      r_pend     <= '0;
      r_pend_vld <= 1'b0;
      r_hold     <= '0;
      msg_ack    <= 1'b0;
      busy       <= 1'b0;
      fnd_serial <= NULL_CODE;
`ifdef FND_BLINK_EN
      r_blink    <= 1'b0;
`endif
    end else begin
      msg_ack <= 1'b0;
      if (val_valid) begin
        r_val      <= val_data;
        r_val_seen <= 1'b1;
      end
      if (err_req) begin
        r_state    <= ERR;
        r_pend_vld <= 1'b0;
        r_hold     <= '0;
`ifdef FND_BLINK_EN
        r_blink    <= 1'b0;
`endif
      end else begin
        case (r_state)
          IDLE: if (w_acc) begin
            r_act   <= msg_code;
            r_hold  <= HOLD;
            msg_ack <= 1'b1;
            r_state <= MSG;
          end
          MSG: if (w_exp) begin
            if (r_pend_vld) begin
              r_act      <= r_pend;
              r_hold     <= HOLD;
              r_pend_vld <= w_acc;
              if (w_acc) begin
                r_pend  <= msg_code;
                msg_ack <= 1'b1;
              end
            end else if (w_acc) begin
              r_act   <= msg_code;
              r_hold  <= HOLD;
              msg_ack <= 1'b1;
            end else begin
              r_hold  <= '0;
              r_state <= IDLE;
            end
          end else begin
            if (tick) r_hold <= r_hold - 4'd1;
            if (w_acc && !r_pend_vld) begin
              r_pend     <= msg_code;
              r_pend_vld <= 1'b1;
              msg_ack    <= 1'b1;
            end
          end
          ERR: begin
            if (err_clr) r_state <= IDLE;
`ifdef FND_BLINK_EN
            if (tick) r_blink <= ~r_blink;
`endif
          end
          default: r_state <= IDLE;
        endcase
      end
      busy       <= r_state != IDLE;
      fnd_serial <= r_state == MSG ? r_act : r_state == ERR ? w_err_disp : r_val_seen ? r_val : NULL_CODE;
    end
  end
endmodule
